// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one fixed-latency synchronous memory port between the instruction
// fetch stage (IF) and the data memory stage (DM). One access is in flight
// at a time. The sequence per access is IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// A starvation counter forces IF to win after MAX_WAIT consecutive DM grants
// taken while IF was waiting. New fetches are not granted while halted=1.
//
// Ports
//   clk1, rst            clock; synchronous active-high reset
//   halted               blocks new IF grants (an IF access in flight completes)
//   if_req/if_addr       fetch request, held until if_ack
//   if_ack/if_rdata      one-cycle fetch completion and instruction word
//   dm_req/dm_we/...     load/store request, held until dm_ack
//   dm_ack/dm_rdata      one-cycle data completion; rdata is 0 for stores
//   m_en/m_we/m_addr/... memory strobe (one cycle per access) and operands
//   m_rdata              memory read data, valid MEM_LAT cycles after m_en
//   grant                01=IF, 10=DM, 00=none (ISSUE through RESP)
//   stall_if/stall_dm    request pending and not being acknowledged
module mem_port_arbiter #(
   parameter int AW       = 10,
   parameter int DW       = 32,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 3
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          halted,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic [1:0]    grant,
   output logic          stall_if,
   output logic          stall_dm
);

   localparam logic [3:0] LAT_C = 4'(MEM_LAT);
   localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t          state_reg;
   logic [3:0]      wait_cnt_reg;
   logic [3:0]      starve_cnt_reg;
   logic            op_we_reg;
   logic            m_en_reg;
   logic            m_we_reg;
   logic [AW-1:0]   m_addr_reg;
   logic [DW-1:0]   m_wdata_reg;
   logic            if_ack_reg;
   logic            dm_ack_reg;
   logic [DW-1:0]   if_rdata_reg;
   logic [DW-1:0]   dm_rdata_reg;
   logic [1:0]      grant_reg;

   logic            if_elig;
   logic            at_limit;
   logic            pick_dm;
   logic            pick_if;

   // DM normally has priority; once the counter has reached its limit an
   // eligible IF request takes the port instead. The counter can only sit at
   // the limit after DM grants made while IF was eligible, so "below limit"
   // and "not at limit" are the same test.
   assign if_elig  = if_req & ~halted;
   assign at_limit = (starve_cnt_reg == MAX_C);
   assign pick_dm  = dm_req & ~(if_elig & at_limit);
   assign pick_if  = if_elig & ~pick_dm;

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         wait_cnt_reg   <= '0;
         starve_cnt_reg <= '0;
         op_we_reg      <= 1'b0;
         m_en_reg       <= 1'b0;
         m_we_reg       <= 1'b0;
         m_addr_reg     <= '0;
         m_wdata_reg    <= '0;
         if_ack_reg     <= 1'b0;
         dm_ack_reg     <= 1'b0;
         if_rdata_reg   <= '0;
         dm_rdata_reg   <= '0;
         grant_reg      <= 2'b00;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pick_dm | pick_if) begin
                  // Operands are captured here so the requester may change
                  // its inputs while the access is in flight.
                  state_reg   <= ST_ISSUE;
                  grant_reg   <= pick_dm ? 2'b10 : 2'b01;
                  m_en_reg    <= 1'b1;
                  m_we_reg    <= pick_dm & dm_we;
                  op_we_reg   <= pick_dm & dm_we;
                  m_addr_reg  <= pick_dm ? dm_addr : if_addr;
                  m_wdata_reg <= pick_dm ? dm_wdata : '0;
                  if (pick_if) begin
                     starve_cnt_reg <= '0;
                  end else if (if_elig && !at_limit) begin
                     starve_cnt_reg <= starve_cnt_reg + 4'd1;
                  end
               end
            end
            ST_ISSUE: begin
               m_en_reg     <= 1'b0;
               m_we_reg     <= 1'b0;
               wait_cnt_reg <= LAT_C;
               state_reg    <= ST_WAIT;
            end
            ST_WAIT: begin
               // Last WAIT cycle: memory data is valid now, so it is
               // captured straight into the owner's rdata register and the
               // ack is raised for the RESP cycle.
               if (wait_cnt_reg == 4'd1) begin
                  state_reg <= ST_RESP;
                  if (grant_reg[1]) begin
                     dm_ack_reg   <= 1'b1;
                     dm_rdata_reg <= op_we_reg ? '0 : m_rdata;
                  end else begin
                     if_ack_reg   <= 1'b1;
                     if_rdata_reg <= m_rdata;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 4'd1;
               end
            end
            ST_RESP: begin
               if_ack_reg <= 1'b0;
               dm_ack_reg <= 1'b0;
               grant_reg  <= 2'b00;
               state_reg  <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_en     = m_en_reg;
   assign m_we     = m_we_reg;
   assign m_addr   = m_addr_reg;
   assign m_wdata  = m_wdata_reg;
   assign if_ack   = if_ack_reg;
   assign dm_ack   = dm_ack_reg;
   assign if_rdata = if_rdata_reg;
   assign dm_rdata = dm_rdata_reg;
   assign grant    = grant_reg;
   assign stall_if = if_req & ~if_ack_reg;
   assign stall_dm = dm_req & ~dm_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: main instance with MEM_LAT=1, second
// instance with MEM_LAT=4 for the latency sweep. A transaction-level model
// schedules each grant by cycle number and checks the main instance's
// outputs every cycle; directed tests add hand-computed literal checks.
module tb_mem_port_arbiter;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int LAT  = 1;
   localparam int MAXW = 3;
   localparam int LATB = 4;

   logic          clk1 = 1'b0;
   logic          rst = 1'b1;
   logic          halted = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          if_ack, dm_ack, m_en, m_we, stall_if, stall_dm;
   logic [DW-1:0] if_rdata, dm_rdata, m_wdata, m_rdata;
   logic [AW-1:0] m_addr;
   logic [1:0]    grant;

   logic          b_dm_req = 1'b0;
   logic [AW-1:0] b_dm_addr = '0;
   logic          b_if_ack, b_dm_ack, b_m_en, b_m_we, b_stall_if, b_stall_dm;
   logic [DW-1:0] b_if_rdata, b_dm_rdata, b_m_wdata, b_m_rdata;
   logic [AW-1:0] b_m_addr;
   logic [1:0]    b_grant;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
      .clk1(clk1), .rst(rst), .halted(halted),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .grant(grant), .stall_if(stall_if), .stall_dm(stall_dm)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LATB), .MAX_WAIT(MAXW)) dut_b (
      .clk1(clk1), .rst(rst), .halted(1'b0),
      .if_req(1'b0), .if_addr('0), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .dm_req(b_dm_req), .dm_we(1'b0), .dm_addr(b_dm_addr), .dm_wdata('0),
      .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
      .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
      .m_rdata(b_m_rdata), .grant(b_grant), .stall_if(b_stall_if), .stall_dm(b_stall_dm)
   );

   always #5 clk1 = ~clk1;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   logic rst_q = 1'b0;

   always @(posedge clk1) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memories: data valid exactly MEM_LAT cycles after the m_en cycle and
   // poisoned otherwise, so capturing on the wrong cycle is visible.
   logic [DW-1:0] mem    [1024];
   logic [DW-1:0] mem_b  [1024];
   logic [DW-1:0] shadow [1024];
   logic [DW-1:0] rd_a;
   logic [DW-1:0] pb [LATB];

   always @(posedge clk1) begin
      if (m_en && m_we) mem[m_addr] <= m_wdata;
      rd_a <= (m_en && !m_we) ? mem[m_addr] : 32'hDEAD_BEEF;
   end
   assign m_rdata = rd_a;

   always @(posedge clk1) begin
      pb[0] <= b_m_en ? mem_b[b_m_addr] : 32'hDEAD_BEEF;
      for (int i = 1; i < LATB; i++) pb[i] <= pb[i-1];
   end
   assign b_m_rdata = pb[LATB-1];

   // Transaction-level model of the main instance.
   bit            armed = 0;
   bit            busy = 0;
   int            g_cyc = 0;
   bit            own_dm = 0;
   bit            op_we = 0;
   logic [AW-1:0] op_addr = '0;
   logic [DW-1:0] op_wdata = '0;
   logic [DW-1:0] op_rd = '0;
   logic [DW-1:0] e_ifr = '0;
   logic [DW-1:0] e_dmr = '0;
   int            starve = 0;

   always @(negedge clk1) begin
      bit       e_en, e_we, e_ia, e_da, if_el, g_dm, g_if;
      logic [1:0] e_gr;
      int       d;
      if (rst_q) begin
         armed = 1; busy = 0; starve = 0; e_ifr = '0; e_dmr = '0;
      end
      if (armed) begin
         e_en = 0; e_we = 0; e_ia = 0; e_da = 0; e_gr = 2'b00;
         if (busy && (cyc - g_cyc) > LAT + 2) busy = 0;
         if (busy) begin
            d    = cyc - g_cyc;
            e_gr = own_dm ? 2'b10 : 2'b01;
            if (d == 1) begin e_en = 1; e_we = op_we; end
            if (d == LAT + 2) begin
               if (own_dm) begin e_da = 1; e_dmr = op_we ? '0 : op_rd; end
               else begin e_ia = 1; e_ifr = op_rd; end
               $display("txn cycle %0d: %s addr=%0h we=%0d data=%0h", cyc,
                        own_dm ? "DM" : "IF", op_addr, op_we, op_we ? op_wdata : op_rd);
            end
         end
         chk("m_en", m_en, e_en);
         chk("m_we", m_we, e_we);
         chk("grant", grant, e_gr);
         chk("if_ack", if_ack, e_ia);
         chk("dm_ack", dm_ack, e_da);
         chk("if_rdata", if_rdata, e_ifr);
         chk("stall_if", stall_if, if_req & ~e_ia);
         chk("stall_dm", stall_dm, dm_req & ~e_da);
         if (e_en) chk("m_addr", m_addr, op_addr);
         if (e_we) chk("m_wdata", m_wdata, op_wdata);
         if (e_da) chk("dm_rdata", dm_rdata, e_dmr);
         // Arbitration decision for this cycle, applied at the next edge.
         if (!busy && !rst) begin
            if_el = if_req && !halted;
            g_dm = 0; g_if = 0;
            if (dm_req && if_el && starve < MAXW) g_dm = 1;
            else if (if_el && starve == MAXW) g_if = 1;
            else if (dm_req) g_dm = 1;
            else if (if_el) g_if = 1;
            if (g_dm || g_if) begin
               busy = 1; g_cyc = cyc; own_dm = g_dm;
               op_we    = g_dm && dm_we;
               op_addr  = g_dm ? dm_addr : if_addr;
               op_wdata = dm_wdata;
               op_rd    = op_we ? '0 : shadow[op_addr];
               if (op_we) shadow[op_addr] = dm_wdata;
               if (g_if) starve = 0;
               else if (if_el && starve < MAXW) starve++;
            end
         end
      end
   end

   // m_en monitor for directed checks.
   int            en_cyc = -1;
   logic [AW-1:0] en_addr = '0;
   bit            log_en = 0;
   logic [1:0]    gq [$];

   always @(negedge clk1) begin
      if (m_en) begin
         en_cyc  = cyc;
         en_addr = m_addr;
         if (log_en) gq.push_back(grant);
      end
   end

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic do_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int ack_at, output logic [DW-1:0] rd);
      dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
      ack_at = -1; rd = '0;
      for (int k = 0; k < 64 && ack_at < 0; k++) begin
         @(negedge clk1);
         if (dm_ack) begin ack_at = cyc; rd = dm_rdata; end
      end
      if (ack_at < 0) chk("dm_ack_timeout", 64'd0, 64'd1);
      step();
      dm_req = 1'b0; dm_we = 1'b0;
   endtask

   task automatic do_if(input logic [AW-1:0] a, output int ack_at, output logic [DW-1:0] rd);
      if_req = 1'b1; if_addr = a;
      ack_at = -1; rd = '0;
      for (int k = 0; k < 64 && ack_at < 0; k++) begin
         @(negedge clk1);
         if (if_ack) begin ack_at = cyc; rd = if_rdata; end
      end
      if (ack_at < 0) chk("if_ack_timeout", 64'd0, 64'd1);
      step();
      if_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, a1, a2, en_n, st_n, first_ack;
      logic [DW-1:0] r1, r2;

      for (int i = 0; i < 1024; i++) begin
         mem[i]   = 32'hA500_0000 + 32'(i) * 32'd17;
         mem_b[i] = 32'hB000_0000 + 32'(i);
      end
      mem[5] = 32'h1234;
      for (int i = 0; i < 1024; i++) shadow[i] = mem[i];

      // Reset values.
      repeat (2) @(negedge clk1);
      chk("rst_grant", grant, 2'b00);
      chk("rst_m_en", m_en, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_acks", {if_ack, dm_ack}, 0);
      chk("rst_rdata", {if_rdata, dm_rdata}, 0);
      step();
      rst = 1'b0;
      step();

      // Single load.
      t0 = cyc;
      do_dm(1'b0, 10'd5, '0, a1, r1);
      chk("load_m_en_cycle", en_cyc - t0, 1);
      chk("load_m_addr", en_addr, 5);
      chk("load_ack_cycle", a1 - t0, 3);
      chk("load_rdata", r1, 32'h1234);
      step();

      // Simultaneous requests: DM first, then IF.
      t0 = cyc;
      fork
         do_dm(1'b0, 10'd12, '0, a1, r1);
         do_if(10'd7, a2, r2);
      join
      chk("simul_dm_ack", a1 - t0, 3);
      chk("simul_if_ack", a2 - t0, 7);
      chk("simul_if_rdata", r2, 32'hA500_0077);
      step();

      // Halt: IF blocked, DM store still served.
      halted = 1'b1; if_req = 1'b1; if_addr = 10'd3;
      en_n = 0; st_n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk1);
         if (m_en) en_n++;
         if (stall_if) st_n++;
      end
      chk("halt_m_en_count", en_n, 0);
      chk("halt_stall_if_count", st_n, 20);
      step();
      do_dm(1'b1, 10'd9, 32'hAA, a1, r1);
      chk("store_rdata", r1, 0);
      chk("store_mem9", mem[9], 32'hAA);
      halted = 1'b0;
      do_if(10'd3, a2, r2);
      chk("unhalt_if_rdata", r2, 32'hA500_0033);
      step();

      // halted rising during an IF access does not cancel it.
      fork
         do_if(10'd40, a2, r2);
         begin step(); step(); halted = 1'b1; end
      join
      chk("halt_mid_rdata", r2, 32'hA500_02A8);
      halted = 1'b0;
      step();

      // Starvation: DM DM DM IF DM.
      gq.delete();
      log_en = 1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
      if_req = 1'b1; if_addr = 10'd30;
      for (int k = 0; k < 60 && gq.size() < 5; k++) @(negedge clk1);
      step();
      dm_req = 1'b0; if_req = 1'b0;
      log_en = 0;
      chk("starve_count", gq.size(), 5);
      if (gq.size() >= 5) begin
         chk("starve_g0", gq[0], 2'b10);
         chk("starve_g1", gq[1], 2'b10);
         chk("starve_g2", gq[2], 2'b10);
         chk("starve_g3", gq[3], 2'b01);
         chk("starve_g4", gq[4], 2'b10);
      end
      repeat (8) step();

      // Latency sweep on the MEM_LAT=4 instance.
      t0 = cyc;
      b_dm_req = 1'b1; b_dm_addr = 10'd17;
      a1 = -1;
      for (int k = 0; k < 40 && a1 < 0; k++) begin
         @(negedge clk1);
         if (b_dm_ack) begin a1 = cyc; r1 = b_dm_rdata; end
      end
      step();
      b_dm_req = 1'b0;
      chk("lat4_ack_cycle", a1 - t0, 6);
      chk("lat4_rdata", r1, 32'hB000_0011);
      step();

      // Reset during WAIT of an IF read.
      t0 = cyc;
      if_req = 1'b1; if_addr = 10'd11;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk1);
      chk("rstw_grant", grant, 2'b00);
      chk("rstw_m_en", {m_en, m_we}, 0);
      chk("rstw_m_addr", m_addr, 0);
      chk("rstw_acks", {if_ack, dm_ack}, 0);
      chk("rstw_rdata", {if_rdata, dm_rdata}, 0);
      first_ack = -1;
      for (int k = 0; k < 30 && first_ack < 0; k++) begin
         if (if_ack) begin first_ack = cyc; r2 = if_rdata; end
         else @(negedge clk1);
      end
      step();
      if_req = 1'b0;
      chk("rstw_ack_cycle", first_ack - t0, 6);
      chk("rstw_if_rdata", r2, 32'hA500_00BB);
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Single-port memory arbiter and access sequencer shared between the pipeline's instruction-fetch stage (IF) and data-memory stage (DM, loads/stores). It accepts held-level requests from both stages and issues one access at a time to a fixed-latency synchronous memory. It returns read data with a one-cycle acknowledge and produces stall indications for the pipeline. A starvation counter guarantees fetch progress under continuous load/store traffic, and fetches are suppressed once the processor has halted.

Parameters:
AW, 10, word-address width
DW, 32, data/instruction width
MEM_LAT, 1, cycles from m_en to valid m_rdata (legal range 1..15)
MAX_WAIT, 3, number of consecutive DM grants with IF pending before IF is forced to win (legal range 1..15)

Ports:
clk1  in  1  single system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
halted  in  1  processor HALTED flag; blocks new IF grants
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DW  fetched instruction, valid while if_ack=1, held until the next IF ack
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_ack  out  1  one-cycle data completion pulse
dm_rdata  out  DW  load data, valid while dm_ack=1; 0 on store acks
m_en  out  1  memory access strobe, exactly one cycle per access
m_we  out  1  memory write enable, qualified by m_en
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid MEM_LAT cycles after the m_en cycle
grant  out  2  current owner: 01=IF, 10=DM, 00=none
stall_if  out  1  if_req & ~if_ack (combinational)
stall_dm  out  1  dm_req & ~dm_ack (combinational)

Behaviour:
- FSM states: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
- Requests are sampled only in IDLE. Requests present in ISSUE, WAIT or RESP are not sampled until the FSM returns to IDLE.
- Arbitration in IDLE, evaluated in order:
  - if dm_req and if_req are both eligible and starve_cnt < MAX_WAIT, DM wins;
  - if starve_cnt == MAX_WAIT and if_req is eligible, IF wins;
  - otherwise, the single eligible requester wins.
- if_req is eligible only when halted=0. dm_req is always eligible.
- Address, write enable and write data are latched at the grant edge. Later changes to the request inputs do not affect the access in flight.
- ISSUE: m_en=1 for exactly one cycle; m_addr, m_we and m_wdata are driven from the latched values; grant is set.
- WAIT: a down-counter is loaded with MEM_LAT. m_rdata is captured at the edge ending the last WAIT cycle.
- RESP: the owner's ack=1 for one cycle and its rdata register is updated. grant stays valid through RESP and clears to 00 in IDLE.
- Latency: request in IDLE cycle T gives ack in cycle T+MEM_LAT+2. Back-to-back accesses are spaced MEM_LAT+3 cycles apart.
- Requester protocol: keep req high until the ack cycle. req still high in the cycle after ack is treated as a new request.
- starve_cnt: 4-bit, saturating at MAX_WAIT.
  - Increments on each DM grant made while if_req=1 and halted=0.
  - Clears to 0 on each IF grant.
  - Left unchanged by DM grants made while IF is not requesting.
- halted rising during an IF access: the access completes and if_ack is still given. Only new IF grants are blocked.
- Reset values: state=IDLE, m_en=0, m_we=0, m_addr=0, m_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, grant=00, starve_cnt=0.
- rst asserted mid-access: the access is abandoned and no ack is issued. A write whose m_en cycle has already occurred is not undone.
- m_we=0 whenever m_en=0.

Test Plan:
- Single load: MEM_LAT=1, dm_req in cycle 0 (addr 5, memory[5]=0x1234) -> m_en in cycle 1 with m_addr=5, dm_ack and dm_rdata=0x1234 in cycle 3, stall_dm high in cycles 0-2.
- Simultaneous requests: if_req and dm_req both held from cycle 0 -> DM acked in cycle 3, IF granted in IDLE cycle 4 and acked in cycle 7.
- Starvation: if_req held while dm_req stays high for 5 back-to-back accesses, MAX_WAIT=3 -> grant order DM, DM, DM, IF, then DM.
- Halt: halted=1 with only if_req high -> m_en stays 0 and stall_if stays high for 20 cycles; a dm_req store (addr 9, data 0xAA) completes with dm_rdata=0 and memory[9]=0xAA.
- Latency sweep: MEM_LAT=4 -> ack arrives exactly 6 cycles after the request is sampled in IDLE.
- Reset during WAIT: rst in cycle 2 of an IF read -> no if_ack is issued, all outputs are 0 and grant=00 in the next cycle, and a pending request is granted normally after rst deasserts.
